// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: shares the off-chip 8-bit memory bus between two requesters
// (port 0 = core, port 1 = loader/debug). Each granted request runs as
// SETUP (1 cycle) -> ACCESS (WAIT_CYCLES cycles) -> DONE (1 cycle, ack pulse).
// Ports:
//   clk, rst                       clock, async active-high reset
//   mN_req/wr/addr/wdata           requester N command (held until ack)
//   mN_ack, mN_rdata               one-cycle completion pulse, read data
//   mem_addr_out/data_out/data_in  external memory address/data pins
//   mem_wr, mem_data_oeb           write strobe (high), data output enable (low)
//   busy                           high whenever a transfer is in flight
module ext_mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [15:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic        m0_ack,
  output logic [7:0]  m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic        m1_ack,
  output logic [7:0]  m1_rdata,
  output logic [15:0] mem_addr_out,
  output logic [7:0]  mem_data_out,
  input  logic [7:0]  mem_data_in,
  output logic        mem_wr,
  output logic        mem_data_oeb,
  output logic        busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last;    // port granted most recently
  logic             sel;     // port owning the current transfer
  logic             sel_wr;  // current transfer is a write

  logic win_c;
  logic any_req_c;

  // Round-robin pick: a lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    any_req_c = m0_req | m1_req;
    win_c     = 1'b0;
    if (m0_req && m1_req) begin
      win_c = ~last;
    end else if (m1_req) begin
      win_c = 1'b1;
    end
  end

  // Bus sequencer; the pin registers double as the latched address/write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      last         <= 1'b1;
      sel          <= 1'b0;
      sel_wr       <= 1'b0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      mem_addr_out <= '0;
      mem_data_out <= '0;
      mem_wr       <= 1'b0;
      mem_data_oeb <= 1'b1;
      busy         <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req_c) begin
            sel   <= win_c;
            last  <= win_c;
            busy  <= 1'b1;
            state <= SETUP;
            if (win_c) begin
              sel_wr       <= m1_wr;
              mem_addr_out <= m1_addr;
              mem_data_oeb <= ~m1_wr;
              if (m1_wr) mem_data_out <= m1_wdata;
            end else begin
              sel_wr       <= m0_wr;
              mem_addr_out <= m0_addr;
              mem_data_oeb <= ~m0_wr;
              if (m0_wr) mem_data_out <= m0_wdata;
            end
          end
        end
        SETUP: begin
          cnt    <= CNT_W'(WAIT_CYCLES - 1);
          mem_wr <= sel_wr;
          state  <= ACCESS;
        end
        ACCESS: begin
          if (cnt == '0) begin
            // Last strobe edge: read data is sampled here, ack shows during DONE.
            mem_wr <= 1'b0;
            state  <= DONE;
            if (sel) begin
              m1_ack <= 1'b1;
              if (!sel_wr) m1_rdata <= mem_data_in;
            end else begin
              m0_ack <= 1'b1;
              if (!sel_wr) m0_rdata <= mem_data_in;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          mem_data_oeb <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Directed bench for ext_mem_arbiter: WAIT_CYCLES=2 main instance plus
// WAIT_CYCLES=1 and WAIT_CYCLES=15 instances for latency/strobe width.
module tb_ext_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [15:0] m0_addr, m1_addr;
  logic [7:0]  m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [7:0]  m0_rdata, m1_rdata;
  logic [15:0] mem_addr_out;
  logic [7:0]  mem_data_out, mem_data_in;
  logic        mem_wr, mem_data_oeb, busy;

  // Short/long wait-state instances, port 0 only.
  logic        w1_req, w1_ack, w1_mem_wr, w1_m1_ack, w1_oeb, w1_busy;
  logic [7:0]  w1_m0_rdata, w1_m1_rdata, w1_dout;
  logic [15:0] w1_addr;
  logic        w15_req, w15_ack, w15_mem_wr, w15_m1_ack, w15_oeb, w15_busy;
  logic [7:0]  w15_m0_rdata, w15_m1_rdata, w15_dout;
  logic [15:0] w15_addr;

  int n_cmp = 0;
  int n_mis = 0;
  int lat, wrc, oebl, nack, ovl;
  int ord [8];
  int at  [8];
  int lat1, lat15, wr1, wr15, ack1, ack15;

  always #5 clk = ~clk;

  ext_mem_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .mem_wr(mem_wr),
    .mem_data_oeb(mem_data_oeb), .busy(busy)
  );

  ext_mem_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst),
    .m0_req(w1_req), .m0_wr(1'b1), .m0_addr(16'h0055), .m0_wdata(8'h99),
    .m0_ack(w1_ack), .m0_rdata(w1_m0_rdata),
    .m1_req(1'b0), .m1_wr(1'b0), .m1_addr(16'h0000), .m1_wdata(8'h00),
    .m1_ack(w1_m1_ack), .m1_rdata(w1_m1_rdata),
    .mem_addr_out(w1_addr), .mem_data_out(w1_dout),
    .mem_data_in(8'h00), .mem_wr(w1_mem_wr),
    .mem_data_oeb(w1_oeb), .busy(w1_busy)
  );

  ext_mem_arbiter #(.WAIT_CYCLES(15)) dut_w15 (
    .clk(clk), .rst(rst),
    .m0_req(w15_req), .m0_wr(1'b1), .m0_addr(16'h00AA), .m0_wdata(8'h66),
    .m0_ack(w15_ack), .m0_rdata(w15_m0_rdata),
    .m1_req(1'b0), .m1_wr(1'b0), .m1_addr(16'h0000), .m1_wdata(8'h00),
    .m1_ack(w15_m1_ack), .m1_rdata(w15_m1_rdata),
    .mem_addr_out(w15_addr), .mem_data_out(w15_dout),
    .mem_data_in(8'h00), .mem_wr(w15_mem_wr),
    .mem_data_oeb(w15_oeb), .busy(w15_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run until any main-instance ack; tick count starts at 1 for the grant edge.
  task automatic run_to_ack;
    lat = 1; wrc = 0; oebl = 0;
    while (!m0_ack && !m1_ack && lat < 30) begin
      tick;
      lat++;
      if (mem_wr) wrc++;
      if (!mem_data_oeb) oebl++;
    end
  endtask

  // Record up to 8 acks over a fixed number of cycles.
  task automatic collect(input int first, input int last_k);
    for (int k = first; k <= last_k; k++) begin
      tick;
      if (m0_ack && m1_ack) ovl++;
      if ((m0_ack || m1_ack) && nack < 8) begin
        ord[nack] = m1_ack ? 1 : 0;
        at[nack]  = k;
        check("ack_addr", 32'(mem_addr_out), m1_ack ? 32'(m1_addr) : 32'(m0_addr));
        nack++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0;
    mem_data_in = '0; w1_req = 0; w15_req = 0;
    tick; tick;

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_oeb", 32'(mem_data_oeb), 32'd1);
    check("rst_wr", 32'(mem_wr), 32'd0);
    check("rst_addr", 32'(mem_addr_out), 32'h0);
    check("rst_dout", 32'(mem_data_out), 32'h0);
    check("rst_ack0", 32'(m0_ack), 32'd0);
    check("rst_ack1", 32'(m1_ack), 32'd0);
    check("rst_rdata0", 32'(m0_rdata), 32'h0);
    rst = 1'b0;

    // Single read, port 0
    m0_wr = 0; m0_addr = 16'h1234; mem_data_in = 8'hA5; m0_req = 1;
    tick;
    check("t1_setup_addr", 32'(mem_addr_out), 32'h1234);
    check("t1_setup_busy", 32'(busy), 32'd1);
    check("t1_setup_oeb", 32'(mem_data_oeb), 32'd1);
    run_to_ack;
    check("t1_latency", 32'(lat), 32'd4);
    check("t1_ack0", 32'(m0_ack), 32'd1);
    check("t1_ack1", 32'(m1_ack), 32'd0);
    check("t1_rdata", 32'(m0_rdata), 32'hA5);
    check("t1_wr_cycles", 32'(wrc), 32'd0);
    check("t1_oeb_low_cycles", 32'(oebl), 32'd0);
    m0_req = 0; mem_data_in = 8'h00;
    tick;
    check("t1_ack_pulse", 32'(m0_ack), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_rdata_hold", 32'(m0_rdata), 32'hA5);

    // Single write, port 1
    m1_wr = 1; m1_addr = 16'hFFFF; m1_wdata = 8'h3C; m1_req = 1;
    tick;
    check("t2_setup_addr", 32'(mem_addr_out), 32'hFFFF);
    check("t2_setup_dout", 32'(mem_data_out), 32'h3C);
    check("t2_setup_oeb", 32'(mem_data_oeb), 32'd0);
    check("t2_setup_wr", 32'(mem_wr), 32'd0);
    run_to_ack;
    check("t2_latency", 32'(lat), 32'd4);
    check("t2_ack1", 32'(m1_ack), 32'd1);
    check("t2_ack0", 32'(m0_ack), 32'd0);
    check("t2_wr_cycles", 32'(wrc), 32'd2);
    check("t2_oeb_low_cycles", 32'(oebl), 32'd3);
    check("t2_done_wr", 32'(mem_wr), 32'd0);
    check("t2_done_dout", 32'(mem_data_out), 32'h3C);
    m1_req = 0;
    tick;
    check("t2_idle_oeb", 32'(mem_data_oeb), 32'd1);
    check("t2_ack_pulse", 32'(m1_ack), 32'd0);
    check("t2_rdata0_hold", 32'(m0_rdata), 32'hA5);

    // Both requesting from reset: alternating grants
    rst = 1'b1;
    m0_wr = 0; m0_addr = 16'h0100; m1_wr = 0; m1_addr = 16'h0200;
    m0_req = 1; m1_req = 1;
    tick;
    check("t3_rst_rdata0", 32'(m0_rdata), 32'h0);
    rst = 1'b0;
    nack = 0; ovl = 0;
    collect(1, 20);
    m0_req = 0; m1_req = 0;
    check("t3_num_acks", 32'(nack), 32'd4);
    check("t3_overlap", 32'(ovl), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("t3_order", 32'(ord[i]), 32'(i % 2));
      check("t3_ack_time", 32'(at[i]), 32'(4 + 5 * i));
    end
    tick;
    check("t3_idle_busy", 32'(busy), 32'd0);

    // Port 0 keeps requesting; port 1 arrives mid-transfer and goes next
    m0_addr = 16'h0300; m1_addr = 16'h0400;
    m0_req = 1;
    tick;
    m1_req = 1;
    nack = 0; ovl = 0;
    collect(2, 9);
    m0_req = 0; m1_req = 0;
    check("t4_num_acks", 32'(nack), 32'd2);
    check("t4_first", 32'(ord[0]), 32'd0);
    check("t4_second", 32'(ord[1]), 32'd1);
    check("t4_second_time", 32'(at[1]), 32'd9);
    tick;
    check("t4_idle_busy", 32'(busy), 32'd0);

    // Reset during the second ACCESS cycle of a write
    m0_wr = 1; m0_addr = 16'h4242; m0_wdata = 8'h77; m0_req = 1;
    tick; tick;
    check("t5_access1_wr", 32'(mem_wr), 32'd1);
    tick;
    check("t5_access2_wr", 32'(mem_wr), 32'd1);
    check("t5_access2_oeb", 32'(mem_data_oeb), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_wr", 32'(mem_wr), 32'd0);
    check("t5_async_oeb", 32'(mem_data_oeb), 32'd1);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_addr", 32'(mem_addr_out), 32'h0);
    m0_wr = 0; m0_addr = 16'h0A0A; m1_wr = 0; m1_addr = 16'h0B0B;
    m1_req = 1;
    tick; tick;
    check("t5_no_ack0", 32'(m0_ack), 32'd0);
    rst = 1'b0;
    tick;
    check("t5_tie_port0", 32'(mem_addr_out), 32'h0A0A);
    run_to_ack;
    check("t5_latency", 32'(lat), 32'd4);
    check("t5_ack0", 32'(m0_ack), 32'd1);
    m0_req = 0; m1_req = 0;
    tick;
    tick;

    // Wait-state extremes
    lat1 = 0; lat15 = 0; wr1 = 0; wr15 = 0; ack1 = 0; ack15 = 0;
    w1_req = 1; w15_req = 1;
    for (int k = 1; k <= 25; k++) begin
      tick;
      if (w1_mem_wr) wr1++;
      if (w15_mem_wr) wr15++;
      if (w1_ack) begin
        ack1++;
        if (lat1 == 0) lat1 = k;
        w1_req = 0;
      end
      if (w15_ack) begin
        ack15++;
        if (lat15 == 0) lat15 = k;
        w15_req = 0;
      end
    end
    check("w1_latency", 32'(lat1), 32'd3);
    check("w1_wr_cycles", 32'(wr1), 32'd1);
    check("w1_acks", 32'(ack1), 32'd1);
    check("w15_latency", 32'(lat15), 32'd17);
    check("w15_wr_cycles", 32'(wr15), 32'd15);
    check("w15_acks", 32'(ack15), 32'd1);
    check("w15_dout", 32'(w15_dout), 32'h66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
